// File: rtl/imem_fetch_buf.sv
// Fetch-stage instruction memory: single-port synchronous RAM with a boot-time load port,
// a valid/ready request path and a small in-order response buffer that supports flush.
module imem_fetch_buf #(
  parameter int AWIDTH    = 12,
  parameter int DWIDTH    = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [AWIDTH-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_data,
  output logic [AWIDTH-1:0] rsp_addr,
  input  logic              rsp_ready,
  input  logic              flush,
  input  logic              ld_we,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [DWIDTH-1:0] ld_data
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int PW = $clog2(BUF_DEPTH);

  logic [DWIDTH-1:0] mem_r [2**AWIDTH];
  logic [DWIDTH-1:0] rd_data_r;
  logic [AWIDTH-1:0] rd_addr_r;
  logic              inflight_r;

  logic [DWIDTH-1:0] buf_data_r [BUF_DEPTH];
  logic [AWIDTH-1:0] buf_addr_r [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     cnt_r;

  logic              pop_s;
  logic              push_s;
  logic              ready_core_s;
  logic              accept_s;
  logic [SW-1:0]     occ_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Handshake decode; reset only gates the visible ready so it never feeds flop data paths.
  always_comb begin
    rsp_valid    = (cnt_r != '0) && !flush;
    pop_s        = rsp_valid && rsp_ready;
    push_s       = inflight_r && !flush;
    occ_s        = SW'(cnt_r) + SW'(inflight_r) - SW'(pop_s);
    ready_core_s = !ld_we && (occ_s < SW'(BUF_DEPTH));
    req_ready    = ready_core_s && rst_n;
    accept_s     = req_valid && ready_core_s;
    rsp_data     = buf_data_r[rd_ptr_r];
    rsp_addr     = buf_addr_r[rd_ptr_r];
  end

  // Single-port RAM: a load owns the port, otherwise an accepted fetch reads it.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_r[ld_addr] <= ld_data;
    end else if (accept_s) begin
      rd_data_r <= mem_r[req_addr];
    end
  end

  // Tracks the read issued last cycle and the address it came from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= 1'b0;
      rd_addr_r  <= '0;
    end else begin
      inflight_r <= accept_s;
      if (accept_s) begin
        rd_addr_r <= req_addr;
      end
    end
  end

  // Response buffer storage; the tail slot is written only by a surviving read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data_r[i] <= '0;
        buf_addr_r[i] <= '0;
      end
    end else if (push_s) begin
      buf_data_r[wr_ptr_r] <= rd_data_r;
      buf_addr_r[wr_ptr_r] <= rd_addr_r;
    end
  end

  // Occupancy and ring pointers; a flush empties the buffer in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      cnt_r <= cnt_r + CW'(push_s) - CW'(pop_s);
    end
  end

endmodule
